// File: rtl/fir_sample_feeder_if.sv
// Sample write channel into fir_sample_feeder.
// The source (master) drives valid/data/last and the feeder (slave) returns ready.
// A sample transfers on a rising edge where both valid and ready are high.
interface fir_sample_feeder_if #(
    parameter int IW = 12
) ();
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [IW-1:0] i_wr_data;
    logic          i_wr_last;

    modport master (
        output i_wr_valid,
        output i_wr_data,
        output i_wr_last,
        input  o_wr_ready
    );

    modport slave (
        input  i_wr_valid,
        input  i_wr_data,
        input  i_wr_last,
        output o_wr_ready
    );
endinterface

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers a block of samples in a FIFO, clocks them into
// an external FIR one per cycle, then flushes the FIR pipeline and forwards
// the first i_output_length results, counting (and discarding) any excess.
// Optional feature macro: FIR_FEEDER_TIMEOUT_EN enables an 8-bit DRAIN
// watchdog that ends a block with o_timeout set when results stop arriving.
module fir_sample_feeder #(
    parameter int IW    = 12,
    parameter int OW    = 31,
    parameter int DEPTH = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [15:0]         i_output_length,
    fir_sample_feeder_if.slave  wr,
    output logic                o_fir_ce,
    output logic [IW-1:0]       o_fir_sample,
    input  logic                i_fir_clean_pip,
    input  logic                i_fir_valid_result,
    input  logic [OW-1:0]       i_fir_result,
    output logic                o_res_valid,
    output logic [OW-1:0]       o_res_data,
    output logic                o_busy,
    output logic                o_done,
    output logic [15:0]         o_dropped,
    output logic                o_timeout
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_next_s;

    // FIFO storage: bit IW is the end-of-block marker
    logic [IW:0]    mem_r [DEPTH];
    logic [AW:0]    wr_ptr_r;
    logic [AW:0]    rd_ptr_r;
    logic           full_s;
    logic           empty_s;
    logic           push_s;
    logic           pop_s;
    logic [IW:0]    rd_entry_s;

    logic [15:0]    len_r;
    logic [15:0]    count_r;
    logic [15:0]    dropped_r;
    logic           fir_ce_r;
    logic [IW-1:0]  fir_sample_r;
    logic           res_valid_r;
    logic [OW-1:0]  res_data_r;

    logic           start_acc_s;
    logic           active_s;
    logic           below_len_s;
    logic           fwd_s;
    logic           drop_s;
    logic           timeout_hit_s;
    logic           busy_s;
    logic           done_s;

    // Ready depends only on registered occupancy, so a pop in the same cycle
    // never opens room for a write into a full FIFO.
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign push_s  = wr.i_wr_valid && !full_s;
    assign pop_s   = (state_r == ST_FEED) && !empty_s;
    assign rd_entry_s = mem_r[rd_ptr_r[AW-1:0]];

    assign start_acc_s = (state_r == ST_IDLE) && i_start;
    assign active_s    = (state_r == ST_FEED) || (state_r == ST_DRAIN);
    assign below_len_s = (count_r < len_r);
    assign fwd_s       = active_s && i_fir_valid_result && below_len_s;
    assign drop_s      = active_s && i_fir_valid_result && !below_len_s;

`ifdef FIR_FEEDER_TIMEOUT_EN
    logic [7:0] wd_r;
    logic       timeout_r;

    // Give up on the 255th DRAIN cycle if the result count is still short
    assign timeout_hit_s = (state_r == ST_DRAIN) && (wd_r == 8'd254) &&
                           (count_r != len_r);

    // Watchdog counts consecutive DRAIN cycles, restarting outside DRAIN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wd_r <= 8'd0;
        end else if (state_r == ST_DRAIN) begin
            wd_r <= wd_r + 8'd1;
        end else begin
            wd_r <= 8'd0;
        end
    end

    // Sticky timeout flag, cleared only by a new block or reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            timeout_r <= 1'b0;
        end else if (start_acc_s) begin
            timeout_r <= 1'b0;
        end else if (timeout_hit_s) begin
            timeout_r <= 1'b1;
        end
    end

    assign o_timeout = timeout_r;
`else
    assign timeout_hit_s = 1'b0;
    assign o_timeout     = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_next_s = ST_FEED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (pop_s && rd_entry_s[IW]) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_FEED;
                end
            end
            ST_DRAIN: begin
                if (count_r == len_r) begin
                    state_next_s = ST_DONE;
                end else if (timeout_hit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State-decoded status outputs
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_FEED:  busy_s = 1'b1;
            ST_DRAIN: busy_s = 1'b1;
            ST_DONE:  done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // FIFO pointers; write and pop may happen in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // FIFO storage write (data only, no reset needed)
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {wr.i_wr_last, wr.i_wr_data};
        end
    end

    // FIR drive: popped sample appears one cycle after the pop; zero while draining
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fir_ce_r     <= 1'b0;
            fir_sample_r <= '0;
        end else begin
            case (state_r)
                ST_FEED: begin
                    if (pop_s) begin
                        fir_ce_r     <= 1'b1;
                        fir_sample_r <= rd_entry_s[IW-1:0];
                    end else begin
                        fir_ce_r     <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    fir_ce_r     <= 1'b0;
                    fir_sample_r <= '0;
                end
                default: begin
                    fir_ce_r     <= 1'b0;
                end
            endcase
        end
    end

    // Block bookkeeping and result forwarding
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            len_r       <= 16'd0;
            count_r     <= 16'd0;
            dropped_r   <= 16'd0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
        end else begin
            res_valid_r <= fwd_s;
            if (fwd_s) begin
                res_data_r <= i_fir_result;
            end
            if (start_acc_s) begin
                len_r     <= i_output_length;
                count_r   <= 16'd0;
                dropped_r <= 16'd0;
            end else begin
                if (fwd_s) begin
                    count_r <= count_r + 16'd1;
                end
                if (drop_s && (dropped_r != 16'hFFFF)) begin
                    dropped_r <= dropped_r + 16'd1;
                end
            end
        end
    end

    // The last popped sample still shows in the first DRAIN cycle; after that
    // the enable follows the FIR flush request directly.
    assign o_fir_ce     = fir_ce_r | ((state_r == ST_DRAIN) & i_fir_clean_pip);
    assign o_fir_sample = fir_sample_r;
    assign o_res_valid  = res_valid_r;
    assign o_res_data   = res_data_r;
    assign o_busy       = busy_s;
    assign o_done       = done_s;
    assign o_dropped    = dropped_r;
    assign wr.o_wr_ready = !full_s;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: table of block scenarios plus
// hand-written impulse, backpressure, reset-in-DRAIN and stall sequences.
// Written samples and expected forwarded results go to scoreboard queues and
// are compared when the DUT strobes o_fir_ce / o_res_valid.
module tb_fir_sample_feeder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] out_len;
    logic        fir_ce;
    logic [11:0] fir_sample;
    logic        clean_pip;
    logic        fir_vr;
    logic [30:0] fir_res;
    logic        res_valid;
    logic [30:0] res_data;
    logic        busy;
    logic        done;
    logic [15:0] dropped;
    logic        timeout;

    fir_sample_feeder_if #(.IW(12)) wr_if ();

    fir_sample_feeder #(.IW(12), .OW(31), .DEPTH(16)) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_start            (start),
        .i_output_length    (out_len),
        .wr                 (wr_if),
        .o_fir_ce           (fir_ce),
        .o_fir_sample       (fir_sample),
        .i_fir_clean_pip    (clean_pip),
        .i_fir_valid_result (fir_vr),
        .i_fir_result       (fir_res),
        .o_res_valid        (res_valid),
        .o_res_data         (res_data),
        .o_busy             (busy),
        .o_done             (done),
        .o_dropped          (dropped),
        .o_timeout          (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] sq[$];
    logic [30:0] rq[$];
    int ce_count  = 0;
    int res_count = 0;

    int mlen  = 0;
    int mcnt  = 0;
    int mdrop = 0;

    typedef struct {
        int len;
        int nsamp;
        int nres;
        int gap;
        int exp_fwd;
        int exp_drop;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every FIR enable and every forwarded result
    always @(negedge clk) begin
        if (fir_ce && !clean_pip) begin
            ce_count++;
            if (sq.size() == 0) begin
                chk("unexpected_fir_ce", 32'(fir_sample), 32'hFFFF_FFFF);
            end else begin
                chk("fir_sample", 32'(fir_sample), 32'(sq.pop_front()));
            end
        end
        if (res_valid) begin
            res_count++;
            if (rq.size() == 0) begin
                chk("unexpected_res_valid", 32'(res_data), 32'hFFFF_FFFF);
            end else begin
                chk("res_data", 32'(res_data), 32'(rq.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_one(input logic [11:0] d, input logic l, input bit push);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        wr_if.i_wr_valid = 1'b1;
        wr_if.i_wr_data  = d;
        wr_if.i_wr_last  = l;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = wr_if.o_wr_ready;
            if (acc && push) sq.push_back(d);
            tick();
            guard++;
        end
        wr_if.i_wr_valid = 1'b0;
        wr_if.i_wr_last  = 1'b0;
        if (!acc) chk("write_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_blk(input int len);
        mlen  = len;
        mcnt  = 0;
        mdrop = 0;
        start   = 1'b1;
        out_len = 16'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic drive_res(input int n);
        for (int i = 0; i < n; i++) begin
            fir_res = 31'($urandom);
            fir_vr  = 1'b1;
            if (mcnt < mlen) begin
                rq.push_back(fir_res);
                mcnt++;
            end else if (mdrop < 65535) begin
                mdrop++;
            end
            tick();
        end
        fir_vr = 1'b0;
    endtask

    task automatic wait_q_empty();
        int guard;
        guard = 0;
        while (sq.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (sq.size() != 0) chk("sample_drain_timeout", 32'(sq.size()), 32'd0);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        int guard;
        seen = 1'b0;
        guard = 0;
        while (!seen && guard < 300) begin
            @(negedge clk);
            seen = done;
            guard++;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({name, "_idle_after_done"}, 32'(busy), 32'd0);
        tick();
    endtask

    task automatic run_block(input vec_t v, input string name);
        int ce0;
        int res0;
        ce0  = ce_count;
        res0 = res_count;
        start_blk(v.len);
        for (int i = 0; i < v.nsamp - 1; i++) begin
            wr_one(12'($urandom), 1'b0, 1'b1);
            for (int g = 0; g < v.gap; g++) tick();
        end
        drive_res(v.nres);
        wr_one(12'($urandom), 1'b1, 1'b1);
        wait_done(name);
        chk({name, "_ce_pulses"}, 32'(ce_count - ce0), 32'(v.nsamp));
        chk({name, "_forwarded"}, 32'(res_count - res0), 32'(v.exp_fwd));
        chk({name, "_dropped"}, 32'(dropped), 32'(v.exp_drop));
        chk({name, "_model_dropped"}, 32'(mdrop), 32'(v.exp_drop));
        chk({name, "_res_queue_empty"}, 32'(rq.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_fir_ce"}, 32'(fir_ce), 32'd0);
        chk({name, "_fir_sample"}, 32'(fir_sample), 32'd0);
        chk({name, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({name, "_res_data"}, 32'(res_data), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_dropped"}, 32'(dropped), 32'd0);
        chk({name, "_timeout"}, 32'(timeout), 32'd0);
        chk({name, "_wr_ready"}, 32'(wr_if.o_wr_ready), 32'd1);
    endtask

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int ce0;
        int res0;
        int acc;
        int idx;
        int guard;
        bit seen;

        vecs[0] = '{2, 9, 2, 0, 2, 0};
        vecs[1] = '{1, 4, 3, 0, 1, 2};
        vecs[2] = '{0, 3, 2, 0, 0, 2};
        vecs[3] = '{3, 5, 3, 3, 3, 0};
        vecs[4] = '{4, 6, 6, 1, 4, 2};
        vecs[5] = '{2, 1, 3, 0, 2, 1};

        rst = 1'b1;
        start = 1'b0;
        out_len = 16'd0;
        clean_pip = 1'b0;
        fir_vr = 1'b0;
        fir_res = 31'd0;
        wr_if.i_wr_valid = 1'b0;
        wr_if.i_wr_data  = 12'd0;
        wr_if.i_wr_last  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");
        tick();

        // Table-driven blocks
        for (int k = 0; k < 6; k++) begin
            run_block(vecs[k], $sformatf("vec%0d", k));
        end

        // Impulse: samples queued before start, then flush tracking in DRAIN
        ce0  = ce_count;
        res0 = res_count;
        wr_one(12'd1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) wr_one(12'd0, 1'b0, 1'b1);
        wr_one(12'd2, 1'b1, 1'b1);
        start_blk(2);
        wait_q_empty();
        tick();
        clean_pip = 1'b1;
        @(negedge clk);
        chk("drain_ce_follows_clean_hi", 32'(fir_ce), 32'd1);
        chk("drain_sample_zero", 32'(fir_sample), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        tick();
        clean_pip = 1'b0;
        @(negedge clk);
        chk("drain_ce_follows_clean_lo", 32'(fir_ce), 32'd0);
        tick();
        drive_res(2);
        wait_done("impulse");
        chk("impulse_ce_pulses", 32'(ce_count - ce0), 32'd9);
        chk("impulse_forwarded", 32'(res_count - res0), 32'd2);
        chk("impulse_dropped", 32'(dropped), 32'd0);

        // Backpressure: 20 writes offered while IDLE, only 16 fit
        ce0 = ce_count;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            wr_if.i_wr_valid = 1'b1;
            wr_if.i_wr_data  = 12'(idx + 100);
            wr_if.i_wr_last  = (idx == 19);
            @(negedge clk);
            if (wr_if.o_wr_ready) begin
                sq.push_back(12'(idx + 100));
                idx++;
            end
            tick();
        end
        chk("bp_accepted_before_start", 32'(idx), 32'd16);
        @(negedge clk);
        chk("bp_ready_low_when_full", 32'(wr_if.o_wr_ready), 32'd0);
        tick();
        mlen = 0; mcnt = 0; mdrop = 0;
        start = 1'b1;
        out_len = 16'd0;
        guard = 0;
        while (idx < 20 && guard < 100) begin
            wr_if.i_wr_valid = 1'b1;
            wr_if.i_wr_data  = 12'(idx + 100);
            wr_if.i_wr_last  = (idx == 19);
            @(negedge clk);
            if (wr_if.o_wr_ready) begin
                sq.push_back(12'(idx + 100));
                idx++;
            end
            tick();
            start = 1'b0;
            guard++;
        end
        wr_if.i_wr_valid = 1'b0;
        wr_if.i_wr_last  = 1'b0;
        chk("bp_all_accepted", 32'(idx), 32'd20);
        wait_done("backpressure");
        chk("bp_ce_pulses", 32'(ce_count - ce0), 32'd20);

        // Reset while draining: abort, lose queued samples, no done
        wr_one(12'd7, 1'b0, 1'b1);
        wr_one(12'd9, 1'b1, 1'b1);
        start_blk(3);
        wait_q_empty();
        drive_res(1);
        wr_one(12'd5, 1'b0, 1'b0);
        wr_one(12'd6, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("drain_reset");
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("drain_reset_no_done", 32'(seen), 32'd0);
        tick();
        run_block('{1, 2, 1, 0, 1, 0}, "post_reset");

        // Too few results: watchdog ends the block, or DRAIN stalls forever
        wr_one(12'd3, 1'b1, 1'b1);
        start_blk(5);
        drive_res(2);
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
`ifdef FIR_FEEDER_TIMEOUT_EN
        chk("stall_done_by_watchdog", 32'(seen), 32'd1);
        chk("stall_timeout_flag", 32'(timeout), 32'd1);
        chk("stall_idle", 32'(busy), 32'd0);
`else
        chk("stall_no_done", 32'(seen), 32'd0);
        chk("stall_busy_held", 32'(busy), 32'd1);
        chk("stall_timeout_tied", 32'(timeout), 32'd0);
`endif
        chk("stall_forwarded_two", 32'(rq.size()), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("final_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_sample_feeder.md
FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

Interface
REQ-001 SHALL have parameter IW, default 12, sample width (signed).
REQ-002 SHALL have parameter OW, default 31, FIR result width (signed).
REQ-003 SHALL have parameter DEPTH, default 16, sample FIFO entries (power of 2, >=2).
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_reset  in  1  reset, synchronous, active-high.
REQ-006 i_start  in  1  begin a block; sampled only in IDLE.
REQ-007 i_output_length  in  16  results to forward per block; latched on accepted i_start.
REQ-008 i_wr_valid / o_wr_ready  in/out  1/1  sample write handshake; transfer when both high.
REQ-009 i_wr_data / i_wr_last  in/in  IW/1  sample; last marks final sample of block.
REQ-010 o_fir_ce / o_fir_sample  out/out  1/IW  clock-enable and sample driven into the FIR.
REQ-011 i_fir_clean_pip  in  1  FIR pipeline-flush request.
REQ-012 i_fir_valid_result / i_fir_result  in/in  1/OW  FIR output strobe and value.
REQ-013 o_res_valid / o_res_data  out/out  1/OW  forwarded result, one-cycle strobe.
REQ-014 o_busy / o_done / o_dropped / o_timeout  out  1/1/16/1  status.

Function
REQ-015 SHALL implement FSM IDLE -> FEED -> DRAIN -> DONE -> IDLE.
REQ-016 IDLE: i_start=1 -> FEED, latch i_output_length, clear result counter and o_dropped.
REQ-017 FIFO: o_wr_ready = !full, computed before any same-cycle pop; no write bypass; writes accepted in every state.
REQ-018 FEED: FIFO non-empty -> pop one entry per cycle; next cycle o_fir_ce=1, o_fir_sample=entry (1-cycle latency).
REQ-019 FEED: FIFO empty -> next cycle o_fir_ce=0; o_fir_sample holds last value.
REQ-020 FEED: popping entry with last=1 -> DRAIN the following cycle.
REQ-021 DRAIN: o_fir_ce SHALL combinationally equal i_fir_clean_pip; o_fir_sample=0; no FIFO pops.
REQ-022 FEED/DRAIN: each i_fir_valid_result with count < latched length -> o_res_valid=1, o_res_data=i_fir_result next cycle, count++.
REQ-023 Results with count >= length SHALL be discarded; o_dropped++ (saturate at 0xFFFF).
REQ-024 DRAIN: count == length (including length 0) -> DONE.
REQ-025 DONE: o_done=1 for exactly one cycle, o_fir_ce=0, then IDLE.
REQ-026 o_busy=1 in FEED and DRAIN, else 0.
REQ-027 i_start outside IDLE SHALL be ignored.
REQ-028 IDLE/DONE: i_fir_valid_result ignored; o_res_valid=0.

Reset
REQ-029 i_reset=1 SHALL, on the next edge, force IDLE, empty FIFO, clear count.
REQ-030 Reset values: o_fir_ce=0, o_fir_sample=0, o_res_valid=0, o_res_data=0, o_busy=0, o_done=0, o_dropped=0, o_timeout=0; o_wr_ready=1 after reset.
REQ-031 Reset mid-block SHALL abort without o_done; queued samples lost.

Configuration
REQ-032 Macro FIR_FEEDER_TIMEOUT_EN defined: 8-bit watchdog counts DRAIN cycles; on 255 without reaching length -> DONE, o_timeout=1 sticky until next accepted i_start or reset.
REQ-033 Macro undefined: no watchdog; DRAIN waits indefinitely; o_timeout tied 0.

Verification
REQ-034 Impulse: write 1,0,0,0,0,0,0,0,2(last), length=2, start -> 9 o_fir_ce pulses with those samples in order, then ce tracks clean_pip; 2 results forwarded; o_done one cycle.
REQ-035 Backpressure: write 20 samples with no start -> o_wr_ready falls after 16 accepts; start -> pops resume, remaining 4 accepted.
REQ-036 Underrun: feed with 3-cycle write gaps -> o_fir_ce=0 in gaps, no sample duplicated or lost.
REQ-037 Excess results: length=1, FIR returns 3 valid results -> o_res_valid once, o_dropped=2.
REQ-038 Reset in DRAIN -> IDLE next cycle, all outputs at reset values, no o_done.
REQ-039 With FIR_FEEDER_TIMEOUT_EN, length=5, only 2 results -> DONE after 255 DRAIN cycles, o_timeout=1; without macro, o_busy stays 1.
